// File: rtl/pixl2sym_dl_pkg.sv
// Shared types and constants for the pixl_to_symbol deadlock watchdog.
package pixl2sym_dl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StReport,
    StHold
  } state_e;

  localparam logic [1:0]  BLK_NONE   = 2'b00;
  localparam logic [7:0]  CHAN_NONE  = 8'hFF;
  localparam int unsigned NUM_CH_DEF = 2;

endpackage

// File: rtl/pixl2sym_dl_chan_scan.sv
// Combinational finder for the first blocked channel at or above a start index.
module pixl2sym_dl_chan_scan
  import pixl2sym_dl_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF
) (
  input  logic [2*NUM_CH-1:0] i_snap,
  input  logic [7:0]          i_start,
  output logic [7:0]          o_next,
  output logic [1:0]          o_code,
  output logic                o_found,
  output logic                o_last
);

  // o_last: no further blocked channel beyond o_next.
  always_comb begin
    o_next  = '0;
    o_code  = BLK_NONE;
    o_found = 1'b0;
    o_last  = 1'b1;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (ch >= int'(i_start) && i_snap[2*ch +: 2] != BLK_NONE) begin
        if (!o_found) begin
          o_found = 1'b1;
          o_next  = 8'(ch);
          o_code  = i_snap[2*ch +: 2];
        end else begin
          o_last = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pixl2sym_deadlock_watchdog.sv
// Debounces the monitor's block flag, freezes per-channel blocking codes on deadlock and
// streams one report record per blocked channel over a valid/ready port.
module pixl2sym_deadlock_watchdog
  import pixl2sym_dl_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned THRESH = 1024,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                enable,
  input  logic                block,
  input  logic [2*NUM_CH-1:0] axis_block_info,
  output logic                deadlock,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [7:0]          rpt_chan,
  output logic [1:0]          rpt_code,
  output logic                rpt_last,
  output logic                done
);

  state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_dl, w_dl_nxt;
  logic [2*NUM_CH-1:0] r_snap, w_snap_nxt;
  logic                r_valid, w_valid_nxt;
  logic [7:0]          r_chan, w_chan_nxt;
  logic [1:0]          r_code, w_code_nxt;
  logic                r_last, w_last_nxt;
  logic                r_done, w_done_nxt;

  logic                w_trig;
  logic                w_xfer;
  logic [2*NUM_CH-1:0] w_scan_in;
  logic [7:0]          w_scan_start;
  logic [7:0]          w_scan_next;
  logic [1:0]          w_scan_code;
  logic                w_scan_found;
  logic                w_scan_last;

  assign w_trig = (r_state == StCount) && enable && block && (r_cnt == CNT_W'(THRESH - 1));
  assign w_xfer = (r_state == StReport) && r_valid && rpt_ready;

  // While counting the scanner looks at live info so the first record is ready on the trigger
  // edge; afterwards it walks the frozen snapshot from the channel just sent.
  assign w_scan_in    = (r_state == StCount) ? axis_block_info : r_snap;
  assign w_scan_start = (r_state == StCount) ? 8'd0 : r_chan + 8'd1;

  pixl2sym_dl_chan_scan #(
    .NUM_CH (NUM_CH)
  ) u_chan_scan (
    .i_snap  (w_scan_in),
    .i_start (w_scan_start),
    .o_next  (w_scan_next),
    .o_code  (w_scan_code),
    .o_found (w_scan_found),
    .o_last  (w_scan_last)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (enable) w_state_nxt = StCount;
      StCount: begin
        if (!enable)     w_state_nxt = StIdle;
        else if (w_trig) w_state_nxt = StReport;
      end
      StReport: if (w_xfer && r_last) w_state_nxt = StHold;
      StHold:   if (!enable) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_dl_nxt    = r_dl;
    w_snap_nxt  = r_snap;
    w_valid_nxt = r_valid;
    w_chan_nxt  = r_chan;
    w_code_nxt  = r_code;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        w_dl_nxt  = 1'b0;
      end
      StCount: begin
        if (!enable) begin
          w_cnt_nxt = '0;
        end else if (w_trig) begin
          w_cnt_nxt   = CNT_W'(THRESH);
          w_dl_nxt    = 1'b1;
          w_snap_nxt  = axis_block_info;
          w_valid_nxt = 1'b1;
          if (w_scan_found) begin
            w_chan_nxt = w_scan_next;
            w_code_nxt = w_scan_code;
            w_last_nxt = w_scan_last;
          end else begin
            w_chan_nxt = CHAN_NONE;
            w_code_nxt = BLK_NONE;
            w_last_nxt = 1'b1;
          end
        end else if (block) begin
          w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      StReport: begin
        if (w_xfer) begin
          if (r_last) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_chan_nxt  = '0;
            w_code_nxt  = BLK_NONE;
            w_last_nxt  = 1'b0;
          end else begin
            w_chan_nxt = w_scan_next;
            w_code_nxt = w_scan_code;
            w_last_nxt = w_scan_last;
          end
        end
      end
      StHold: begin
        if (!enable) begin
          w_dl_nxt  = 1'b0;
          w_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_cnt   <= '0;
      r_dl    <= 1'b0;
      r_snap  <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_code  <= BLK_NONE;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_dl    <= w_dl_nxt;
      r_snap  <= w_snap_nxt;
      r_valid <= w_valid_nxt;
      r_chan  <= w_chan_nxt;
      r_code  <= w_code_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign deadlock  = r_dl;
  assign stall_cnt = r_cnt;
  assign rpt_valid = r_valid;
  assign rpt_chan  = r_chan;
  assign rpt_code  = r_code;
  assign rpt_last  = r_last;
  assign done      = r_done;

endmodule
